// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit owning HI/LO: radix-2^MUL_BPC shift-add multiply, restoring divide.
// Define ITER_MDU_MAC_EN to enable madd/maddu/msub/msubu (ops 7-10); otherwise they decode as none.
module iter_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW        = $clog2(WIDTH);
  localparam int MUL_STEPS = WIDTH / MUL_BPC;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;     // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [WIDTH-1:0]     opb;     // multiplicand or divisor magnitude
  logic                 neg_q;
  logic                 neg_r;
  logic                 div_zero;
  logic                 op_div;
`ifdef ITER_MDU_MAC_EN
  logic                 mac_add;
  logic                 mac_sub;
  logic                 dec_add;
  logic                 dec_sub;
`endif

  logic dec_mul, dec_div, dec_sgn, dec_mthi, dec_mtlo;

  always_comb begin
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    dec_sgn  = 1'b0;
    dec_mthi = 1'b0;
    dec_mtlo = 1'b0;
`ifdef ITER_MDU_MAC_EN
    dec_add  = 1'b0;
    dec_sub  = 1'b0;
`endif
    case (op)
      OP_MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
      OP_MULTU: dec_mul = 1'b1;
      OP_DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
      OP_DIVU:  dec_div = 1'b1;
      OP_MTHI:  dec_mthi = 1'b1;
      OP_MTLO:  dec_mtlo = 1'b1;
`ifdef ITER_MDU_MAC_EN
      OP_MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_add = 1'b1; end
      OP_MADDU: begin dec_mul = 1'b1; dec_add = 1'b1; end
      OP_MSUB:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_sub = 1'b1; end
      OP_MSUBU: begin dec_mul = 1'b1; dec_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign busy = (start && (dec_mul || dec_div) && state == IDLE && !flush) || (state != IDLE);

  logic [WIDTH-1:0] abs_rs, abs_rt;
  assign abs_rs = (dec_sgn && rs[WIDTH-1]) ? -rs : rs;
  assign abs_rt = (dec_sgn && rt[WIDTH-1]) ? -rt : rt;

  // Multiply step: add multiplicand * low digit to the upper half, then shift the pair right.
  logic [WIDTH+MUL_BPC-1:0]   mul_sum;
  logic [2*WIDTH+MUL_BPC-1:0] mul_wide;
  logic [2*WIDTH-1:0]         mul_next;
  assign mul_sum  = {{MUL_BPC{1'b0}}, acc[2*WIDTH-1:WIDTH]}
                  + ({{MUL_BPC{1'b0}}, opb} * {{WIDTH{1'b0}}, acc[MUL_BPC-1:0]});
  assign mul_wide = {mul_sum, acc[WIDTH-1:0]};
  assign mul_next = (2*WIDTH)'(mul_wide >> MUL_BPC);

  logic [WIDTH:0]     div_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};
  assign div_next = {div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0],
                     acc[WIDTH-2:0], ~div_diff[WIDTH]};

  logic [WIDTH-1:0]   fix_q, fix_r;
  logic [2*WIDTH-1:0] signed_res, fix_res;
  always_comb begin
    fix_q      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fix_r      = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    signed_res = op_div ? {fix_r, fix_q} : (neg_q ? -acc : acc);
    fix_res    = signed_res;
`ifdef ITER_MDU_MAC_EN
    if (mac_add)      fix_res = {hi, lo} + signed_res;
    else if (mac_sub) fix_res = {hi, lo} - signed_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      op_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
`ifdef ITER_MDU_MAC_EN
      mac_add  <= 1'b0;
      mac_sub  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            if (dec_mthi) hi <= rs;
            if (dec_mtlo) lo <= rs;
            if (dec_mul) begin
              state    <= MUL;
              cnt      <= CW'(MUL_STEPS - 1);
              acc      <= {{WIDTH{1'b0}}, abs_rt};
              opb      <= abs_rs;
              neg_q    <= dec_sgn & (rs[WIDTH-1] ^ rt[WIDTH-1]);
              neg_r    <= 1'b0;
              op_div   <= 1'b0;
              div_zero <= 1'b0;
            end
            if (dec_div) begin
              state    <= DIV;
              cnt      <= CW'(WIDTH - 1);
              acc      <= {{WIDTH{1'b0}}, abs_rs};
              opb      <= abs_rt;
              neg_q    <= dec_sgn & (rs[WIDTH-1] ^ rt[WIDTH-1]);
              neg_r    <= dec_sgn & rs[WIDTH-1];
              op_div   <= 1'b1;
              div_zero <= (rt == '0);
            end
`ifdef ITER_MDU_MAC_EN
            mac_add <= dec_add;
            mac_sub <= dec_sub;
`endif
          end
          MUL: begin
            acc <= mul_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) state <= FIX;
          end
          DIV: begin
            acc <= div_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) state <= FIX;
          end
          FIX: begin
            if (!div_zero) {hi, lo} <= fix_res;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iter_mdu.sv
// Self-checking bench for iter_mdu: directed vector table, multi-cycle corner sequences, random ops vs model.
module tb_iter_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [3:0]   op;
  logic [W-1:0] rs, rt, hi, lo;
  logic         busy, done;

  iter_mdu #(.WIDTH(W), .MUL_BPC(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, h, l;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic int lat(input logic [3:0] o);
    case (o)
      4'd1, 4'd2: return 9;
      4'd3, 4'd4: return 33;
`ifdef ITER_MDU_MAC_EN
      4'd7, 4'd8, 4'd9, 4'd10: return 9;
`endif
      default: return 0;
    endcase
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l);
    longint      sa, sb;
    logic [63:0] up, sp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    sp = 64'(sa * sb);
    case (o)
      4'd1: {h, l} = sp;
      4'd2: {h, l} = up;
      4'd3: if (b != 0) begin h = 32'(sa % sb); l = 32'(sa / sb); end
      4'd4: if (b != 0) begin h = a % b; l = a / b; end
      4'd5: h = a;
      4'd6: l = a;
`ifdef ITER_MDU_MAC_EN
      4'd7:  {h, l} = {h, l} + sp;
      4'd8:  {h, l} = {h, l} + up;
      4'd9:  {h, l} = {h, l} - sp;
      4'd10: {h, l} = {h, l} - up;
`endif
      default: ;
    endcase
  endtask

  task automatic kick(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      output logic acc_busy);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    #1 acc_busy = busy;
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
  endtask

  task automatic wait_done(output int cyc, output int bcyc, output logic busy_at_done);
    cyc = 0; bcyc = 0; busy_at_done = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        busy_at_done = busy;
        break;
      end
      if (busy) bcyc++;
    end
  endtask

  task automatic run_long(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    logic ab, bd;
    int   c, bc, l;
    l = lat(o);
    kick(o, a, b, ab);
    check({name, " accept busy"}, 64'(ab), 64'd1);
    wait_done(c, bc, bd);
    check({name, " latency"}, 64'(c), 64'(l + 1));
    check({name, " busy cycles"}, 64'(bc), 64'(l));
    check({name, " busy with done"}, 64'(bd), 64'd0);
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({name, " done pulse"}, 64'(done), 64'd0);
  endtask

  task automatic set_reg(input logic [3:0] o, input logic [31:0] v);
    logic ab;
    kick(o, v, 32'h0, ab);
    check("mthi/mtlo busy", 64'(ab), 64'd0);
    model(o, v, 32'h0, m_hi, m_lo);
    @(negedge clk);
    check("mthi/mtlo hilo", {hi, lo}, {m_hi, m_lo});
    check("mthi/mtlo done", 64'(done), 64'd0);
  endtask

  task automatic no_op(input string name, input logic [3:0] o);
    logic ab;
    kick(o, $urandom, $urandom, ab);
    check({name, " accept busy"}, 64'(ab), 64'd0);
    @(negedge clk);
    check({name, " busy after"}, 64'(busy), 64'd0);
    check({name, " hilo"}, {hi, lo}, {m_hi, m_lo});
    repeat (3) @(negedge clk);
    check({name, " done"}, 64'(done), 64'd0);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic vec_t mk(input string n, input logic [3:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.h = h; v.l = l;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ab;
    int   c, bc, nd;
    logic bd;
    logic [3:0] o;
    logic [31:0] a, b, eh, el;
    logic [3:0] ops[$];

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);

    vecs.push_back(mk("mult -2*3",      4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA));
    vecs.push_back(mk("multu max*max",  4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001));
    vecs.push_back(mk("div -7/2",       4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD));
    vecs.push_back(mk("divu 7/0",       4'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD));
    vecs.push_back(mk("div min/-1",     4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000));
    vecs.push_back(mk("divu max/16",    4'd4, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF));
    vecs.push_back(mk("mult min*min",   4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000));
    vecs.push_back(mk("div 7/-2",       4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD));
    vecs.push_back(mk("divu 5/max",     4'd4, 32'd5,         32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000));
    vecs.push_back(mk("multu x*16",     4'd2, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780));
    vecs.push_back(mk("mult maxpos*-1", 4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001));

    foreach (vecs[i]) begin
      run_long(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].l);
      m_hi = vecs[i].h;
      m_lo = vecs[i].l;
    end

    // Flush mid-multiply: HI keeps the mthi value and no done appears.
    set_reg(4'd5, 32'h1234);
    kick(4'd1, 32'd5, 32'd6, ab);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy drop", 64'(busy), 64'd0);
    check("flush hilo", {hi, lo}, {32'h1234, m_lo});
    count_done(12, nd);
    check("flush no done", 64'(nd), 64'd0);
    run_long("mult 5*6 after flush", 4'd1, 32'd5, 32'd6, 32'd0, 32'd30);
    m_hi = 32'd0; m_lo = 32'd30;

    // Flush in the FIX cycle suppresses the commit.
    kick(4'd2, 32'd3, 32'd3, ab);
    repeat (9) @(negedge clk);
    check("fix-flush busy in fix", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    count_done(12, nd);
    check("fix-flush no done", 64'(nd), 64'd0);
    check("fix-flush hilo", {hi, lo}, {m_hi, m_lo});
    check("fix-flush busy", 64'(busy), 64'd0);

    // Start while busy is ignored.
    kick(4'd3, 32'd100, 32'd7, ab);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 4'd4; rs = 32'd1; rt = 32'd1;
    #1 check("ignored start busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
    wait_done(c, bc, bd);
    check("ignored start latency", 64'(c), 64'd29);
    check("ignored start hilo", {hi, lo}, {32'd2, 32'd14});
    m_hi = 32'd2; m_lo = 32'd14;
    @(negedge clk);
    check("ignored start no follow-on", 64'(busy), 64'd0);

    // Start with flush in IDLE is ignored, including mthi.
    @(negedge clk);
    start = 1'b1; op = 4'd5; rs = 32'hDEAD; flush = 1'b1;
    #1 check("flush+mthi busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0; op = 4'd0;
    @(negedge clk);
    check("flush+mthi hi", 64'(hi), 64'(m_hi));
    start = 1'b1; op = 4'd1; rs = 32'd9; rt = 32'd9; flush = 1'b1;
    #1 check("flush+mult accept busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0; op = 4'd0;
    @(negedge clk);
    check("flush+mult stays idle", 64'(busy), 64'd0);
    count_done(12, nd);
    check("flush+mult no done", 64'(nd), 64'd0);

    no_op("op 11", 4'd11);
    no_op("op 0", 4'd0);

`ifdef ITER_MDU_MAC_EN
    set_reg(4'd5, 32'd0);
    set_reg(4'd6, 32'd10);
    run_long("madd -1*4", 4'd7, 32'hFFFF_FFFF, 32'd4, 32'd0, 32'd6);
    run_long("msubu 2*3", 4'd10, 32'd2, 32'd3, 32'd0, 32'd0);
    run_long("maddu max*2", 4'd8, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
    run_long("msub -1*1", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF);
    m_hi = 32'd1; m_lo = 32'hFFFF_FFFF;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
`else
    set_reg(4'd5, 32'd0);
    set_reg(4'd6, 32'd10);
    no_op("madd disabled", 4'd7);
    no_op("msubu disabled", 4'd10);
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
`endif

    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, ops.size() - 1)];
      a = rnd();
      b = rnd();
      if (o == 4'd5 || o == 4'd6) begin
        set_reg(o, a);
      end else begin
        eh = m_hi; el = m_lo;
        model(o, a, b, eh, el);
        run_long($sformatf("rand%0d op%0d %h,%h", i, o, a, b), o, a, b, eh, el);
        m_hi = eh; m_lo = el;
      end
    end

    // Reset mid-divide clears HI/LO and returns to idle.
    set_reg(4'd5, 32'hA5A5_A5A5);
    kick(4'd3, 32'd12345, 32'd67, ab);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid-div reset hilo", {hi, lo}, 64'd0);
    check("mid-div reset busy", 64'(busy), 64'd0);
    check("mid-div reset done", 64'(done), 64'd0);
    m_hi = '0; m_lo = '0;
    run_long("mult after reset", 4'd1, 32'd5, 32'd6, 32'd0, 32'd30);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
